cnn_frame_sequencer: RTL and testbench



---
 rtl/cnn_ctrl_pkg.sv | 51 +++++
 rtl/cnn_roi_window.sv | 72 +++++++
 rtl/cnn_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the CNN frame sequencer.
// FSM state encoding, message codes, class indices, argmax helper.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        STREAM,
        WAIT_RESULT,
        DECIDE
    } state_t;

    localparam logic [2:0] MSG_NONE = 3'b000;
    localparam logic [2:0] MSG_CIR  = 3'b001;
    localparam logic [2:0] MSG_TRI  = 3'b010;
    localparam logic [2:0] MSG_REC  = 3'b011;

    localparam logic [1:0] CLS_CIR = 2'd0;
    localparam logic [1:0] CLS_TRI = 2'd1;
    localparam logic [1:0] CLS_REC = 2'd2;

    // Strict greater-than keeps ties on the lower index.
    function automatic logic [1:0] argmax3(
        input logic signed [31:0] s0,
        input logic signed [31:0] s1,
        input logic signed [31:0] s2
    );
        logic signed [31:0] best;
        logic [1:0]         idx;
        best = s0;
        idx  = CLS_CIR;
        if (s1 > best) begin
            best = s1;
            idx  = CLS_TRI;
        end
        if (s2 > best) begin
            idx = CLS_REC;
        end
        return idx;
    endfunction

    function automatic logic [2:0] msg_of(input logic [1:0] cls);
        case (cls)
            CLS_CIR: return MSG_CIR;
            CLS_TRI: return MSG_TRI;
            CLS_REC: return MSG_REC;
            default: return MSG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cnn_roi_window.sv
// Camera sync edge detection, pixel x/y counters and ROI window decode.
// Ports: clk, rst_n, cam_vsync, cam_href in; in_roi, roi_last, frame_start out.
module cnn_roi_window #(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int ROI_X0     = 306,
    parameter int ROI_Y0     = 226,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cam_vsync,
    input  logic cam_href,
    output logic in_roi,
    output logic roi_last,
    output logic frame_start
);

    localparam int XW = $clog2(SRC_WIDTH + 1);
    localparam int YW = $clog2(SRC_HEIGHT + 1);

    localparam logic [XW-1:0] X_LO = XW'(ROI_X0);
    localparam logic [XW-1:0] X_HI = XW'(ROI_X0 + IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LO = YW'(ROI_Y0);
    localparam logic [YW-1:0] Y_HI = YW'(ROI_Y0 + IMG_HEIGHT - 1);

    logic          vsync_q;
    logic          vsync_qq;
    logic          href_q;
    logic          href_qq;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          href_fall;

    assign href_fall   = href_qq & ~href_q;
    assign frame_start = vsync_q & ~vsync_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            vsync_q  <= cam_vsync;
            vsync_qq <= vsync_q;
            href_q   <= cam_href;
            href_qq  <= href_q;
            if (href_fall) begin
                x <= '0;
            end else if (href_q) begin
                x <= x + 1'b1;
            end
            if (frame_start) begin
                y <= '0;
            end else if (href_fall) begin
                y <= y + 1'b1;
            end
        end
    end

    // x/y describe the pixel currently held in the registered data copy.
    assign in_roi = href_q
                 && (x >= X_LO) && (x <= X_HI)
                 && (y >= Y_LO) && (y <= Y_HI);

    assign roi_last = in_roi && (x == X_HI) && (y == Y_HI);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller: crops the camera ROI into the CNN and latches the class.
// Ports: clk, rst_n, en, freeze, cam_*, class_valid, score0..2 in; cnn_*, result_*, msg_code, busy, timeout_err out.
module cnn_frame_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int ROI_X0     = 306,
    parameter int ROI_Y0     = 226,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               freeze,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic               cnn_flush,
    output logic               cnn_valid,
    output logic [7:0]         cnn_data,
    input  logic               class_valid,
    input  logic signed [31:0] score0,
    input  logic signed [31:0] score1,
    input  logic signed [31:0] score2,
    output logic               result_valid,
    output logic [1:0]         result_class,
    output logic [2:0]         msg_code,
    output logic               busy,
    output logic               timeout_err
);

    localparam int            TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    data_q;
    logic [TW-1:0] timer;
    logic [1:0]    winner;
    logic          timer_clr;
    logic          timeout_hit;
    logic          in_roi;
    logic          roi_last;
    logic          frame_start;
    logic          take_pix;
    logic          take_class;
    logic          publish;

    cnn_roi_window #(
        .SRC_WIDTH  (SRC_WIDTH),
        .SRC_HEIGHT (SRC_HEIGHT),
        .ROI_X0     (ROI_X0),
        .ROI_Y0     (ROI_Y0),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_win (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .in_roi      (in_roi),
        .roi_last    (roi_last),
        .frame_start (frame_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnn_flush   = 1'b0;
        timer_clr   = 1'b0;
        timeout_hit = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = WAIT_VS;
                end
                WAIT_VS: begin
                    if (frame_start) begin
                        state_nx  = STREAM;
                        cnn_flush = 1'b1;
                    end
                end
                STREAM: begin
                    // A new vsync restarts a truncated frame in place.
                    if (frame_start) begin
                        cnn_flush = 1'b1;
                    end else if (roi_last) begin
                        state_nx  = WAIT_RESULT;
                        timer_clr = 1'b1;
                    end
                end
                WAIT_RESULT: begin
                    if (class_valid) begin
                        state_nx = DECIDE;
                    end else if (timer == TMAX) begin
                        state_nx    = WAIT_VS;
                        timeout_hit = 1'b1;
                    end
                end
                DECIDE: begin
                    state_nx = WAIT_VS;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == STREAM) || (state == WAIT_RESULT);
    assign take_pix   = en && (state == STREAM) && in_roi && !frame_start;
    assign take_class = en && (state == WAIT_RESULT) && class_valid;
    assign publish    = en && (state == DECIDE) && !freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            cnn_valid    <= 1'b0;
            cnn_data     <= '0;
            timer        <= '0;
            winner       <= CLS_CIR;
            result_valid <= 1'b0;
            result_class <= CLS_CIR;
            msg_code     <= MSG_NONE;
            timeout_err  <= 1'b0;
        end else begin
            data_q    <= cam_data;
            cnn_valid <= take_pix;
            if (take_pix) begin
                cnn_data <= data_q;
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (state == WAIT_RESULT) begin
                timer <= timer + 1'b1;
            end
            if (take_class) begin
                winner <= argmax3(score0, score1, score2);
            end
            result_valid <= publish;
            if (publish) begin
                result_class <= winner;
                msg_code     <= msg_of(winner);
            end
            if (cnn_flush) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer on an 8x6 source with a 4x3 ROI.
// ROI pixels are scoreboarded with their expected output cycle.
module tb_cnn_frame_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               freeze = 1'b0;
    logic               cam_vsync = 1'b0;
    logic               cam_href = 1'b0;
    logic [7:0]         cam_data = '0;
    logic               class_valid = 1'b0;
    logic signed [31:0] score0 = '0;
    logic signed [31:0] score1 = '0;
    logic signed [31:0] score2 = '0;
    logic               cnn_flush;
    logic               cnn_valid;
    logic [7:0]         cnn_data;
    logic               result_valid;
    logic [1:0]         result_class;
    logic [2:0]         msg_code;
    logic               busy;
    logic               timeout_err;

    cnn_frame_sequencer #(
        .SRC_WIDTH  (8),
        .SRC_HEIGHT (6),
        .ROI_X0     (2),
        .ROI_Y0     (1),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .freeze       (freeze),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .cnn_flush    (cnn_flush),
        .cnn_valid    (cnn_valid),
        .cnn_data     (cnn_data),
        .class_valid  (class_valid),
        .score0       (score0),
        .score1       (score1),
        .score2       (score2),
        .result_valid (result_valid),
        .result_class (result_class),
        .msg_code     (msg_code),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;
    int   flush_cnt = 0;
    int   rv_cnt = 0;
    int   last_flush_cyc = -1;
    int   vs_cyc = 0;
    int   last_roi_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cnn_flush) begin
                flush_cnt++;
                last_flush_cyc = cyc;
            end
            if (result_valid) rv_cnt++;
            if (cnn_valid) begin
                valid_cnt++;
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_valid data=%0d cyc=%0d",
                           cnn_data, cyc);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    total++;
                    assert (cnn_data === 8'(e.data) && cyc == e.cyc) else begin
                        bad++;
                        $error("FAIL roi_pixel got=%0d@%0d expected=%0d@%0d",
                               cnn_data, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        tick();
        cam_vsync = 1'b1;
        vs_cyc = cyc;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int y, input int n_px, input bit push);
        for (int x = 0; x < n_px; x++) begin
            tick();
            cam_href = 1'b1;
            cam_data = 8'(y * 8 + x);
            if (push && x >= 2 && x <= 5 && y >= 1 && y <= 3)
                sb.push_back('{y * 8 + x, cyc + 2});
            if (x == 5 && y == 3) last_roi_cyc = cyc;
        end
        tick();
        cam_href = 1'b0;
        cam_data = '0;
        tick();
        tick();
    endtask

    task automatic run_frame();
        vs_pulse();
        for (int y = 0; y < 4; y++) drive_line(y, 8, 1'b1);
    endtask

    task automatic send_class(input int a, input int b, input int c);
        tick();
        class_valid = 1'b1;
        score0 = a;
        score1 = b;
        score2 = c;
        tick();
        class_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int base;
        int rvb;
        int fb;
        int t_err;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {cnn_flush, cnn_valid, cnn_data, result_valid,
            result_class, msg_code, busy, timeout_err}, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        tick();

        chk("busy_before_frame", busy, 0);
        fb = flush_cnt;
        base = valid_cnt;
        vs_pulse();
        chk("flush_a_count", flush_cnt - fb, 1);
        chk("flush_a_cycle", last_flush_cyc, vs_cyc + 1);
        chk("busy_stream", busy, 1);
        for (int y = 0; y < 4; y++) drive_line(y, 8, 1'b1);
        chk("roi_count_a", valid_cnt - base, 12);
        chk("sb_empty_a", sb.size(), 0);
        chk("busy_wait_result", busy, 1);
        rvb = rv_cnt;
        send_class(-5, 7, 7);
        chk("class_a", result_class, 1);
        chk("msg_a", msg_code, 3'b010);
        chk("rv_a", rv_cnt - rvb, 1);
        chk("busy_after_decide", busy, 0);

        run_frame();
        rvb = rv_cnt;
        send_class(100, -1, 3);
        chk("class_b", result_class, 0);
        chk("msg_b", msg_code, 3'b001);
        chk("rv_b", rv_cnt - rvb, 1);

        freeze = 1'b1;
        run_frame();
        rvb = rv_cnt;
        send_class(0, 0, 9);
        chk("class_frozen", result_class, 0);
        chk("msg_frozen", msg_code, 3'b001);
        chk("rv_frozen", rv_cnt - rvb, 0);
        freeze = 1'b0;

        run_frame();
        rvb = rv_cnt;
        send_class(0, 0, 9);
        chk("class_d", result_class, 2);
        chk("msg_d", msg_code, 3'b011);
        chk("rv_d", rv_cnt - rvb, 1);

        run_frame();
        t_err = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                t_err = cyc;
                break;
            end
        end
        chk("timeout_cycle", t_err, last_roi_cyc + 18);
        chk("timeout_busy", busy, 0);

        fb = flush_cnt;
        vs_pulse();
        chk("flush_after_timeout", flush_cnt - fb, 1);
        chk("timeout_cleared", timeout_err, 0);
        base = valid_cnt;
        drive_line(0, 8, 1'b1);
        drive_line(1, 8, 1'b1);
        drive_line(2, 3, 1'b1);
        chk("truncated_count", valid_cnt - base, 5);
        fb = flush_cnt;
        base = valid_cnt;
        vs_pulse();
        chk("flush_truncated", flush_cnt - fb, 1);
        chk("flush_trunc_cycle", last_flush_cyc, vs_cyc + 1);
        for (int y = 0; y < 4; y++) drive_line(y, 8, 1'b1);
        chk("restart_count", valid_cnt - base, 12);
        chk("sb_empty_restart", sb.size(), 0);
        rvb = rv_cnt;
        send_class(3, -8, 3);
        chk("class_tie", result_class, 0);
        chk("msg_tie", msg_code, 3'b001);
        chk("rv_tie", rv_cnt - rvb, 1);

        vs_pulse();
        drive_line(0, 8, 1'b0);
        for (int x = 0; x < 8; x++) begin
            tick();
            cam_href = 1'b1;
            cam_data = 8'(8 + x);
            if (x == 2) sb.push_back('{10, cyc + 2});
            if (x == 4) en = 1'b0;
            if (x == 5) begin
                @(negedge clk);
                chk("en_drop_valid", cnn_valid, 0);
                chk("en_drop_busy", busy, 0);
            end
        end
        tick();
        cam_href = 1'b0;
        tick();
        tick();
        chk("sb_empty_en_drop", sb.size(), 0);

        rvb = rv_cnt;
        send_class(0, 9, 0);
        chk("class_ignored_rv", rv_cnt - rvb, 0);
        chk("class_held", result_class, 0);
        chk("msg_held", msg_code, 3'b001);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {cnn_flush, cnn_valid, cnn_data,
            result_valid, result_class, msg_code, busy, timeout_err}, 0);
        chk("async_reset_msg", msg_code, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
